// File: rtl/relay_modulator.sv
// relay_modulator: turns relay framer envelope bits into tag load modulation or reader carrier pauses
module relay_modulator #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_tick,
  input  logic             data_in,
  input  logic [2:0]       mod_type,
  output logic             load_mod,
  output logic             carrier_off,
  output logic             busy,
  output logic [CNT_W-1:0] tx_bits
);
  localparam logic [1:0] IDLE = 2'd0, TX = 2'd1, DRAIN = 2'd2;
  localparam logic [2:0] TAGSIM_MOD = 3'b010, READER_MOD = 3'b100;
  localparam int DW = $clog2(DEPTH + 1);
  logic [1:0]       state;
  logic             kind;
  logic [DEPTH-1:0] dl, dl_nx;
  logic [3:0]       sc_cnt;
  logic [DW-1:0]    drain_cnt;
  logic             is_tag, is_rdr, match, busy_c, tx_bit;
  logic [CNT_W-1:0] tx_inc;
  if (DEPTH == 1) begin : g_dl1
    assign dl_nx = data_in;
  end else begin : g_dln
    assign dl_nx = {dl[DEPTH-2:0], data_in};
  end
  assign is_tag = mod_type == TAGSIM_MOD;
  assign is_rdr = mod_type == READER_MOD;
  assign match  = kind ? is_rdr : is_tag;
  assign busy_c = state != IDLE;
  assign tx_bit = dl[DEPTH-1];
  assign tx_inc = &tx_bits ? tx_bits : tx_bits + 1'b1;
  // kind: 0 = tag load modulation, 1 = reader carrier pauses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      kind        <= 1'b0;
      dl          <= '0;
      sc_cnt      <= '0;
      drain_cnt   <= '0;
      tx_bits     <= '0;
      load_mod    <= 1'b0;
      carrier_off <= 1'b0;
      busy        <= 1'b0;
    end else begin
      sc_cnt      <= sc_cnt + 4'd1;
      load_mod    <= busy_c & ~kind & tx_bit & sc_cnt[3];
      carrier_off <= busy_c & kind & ~tx_bit;
      busy        <= busy_c;
      if (bit_tick) begin
        dl <= dl_nx;
        if (state == IDLE) begin
          if (is_tag | is_rdr) begin
            state   <= TX;
            kind    <= is_rdr;
            tx_bits <= '0;
          end
        end else begin
          tx_bits <= tx_inc;
          if (match) state <= TX;
          else if (state == TX) begin
            state     <= DRAIN;
            drain_cnt <= DW'(DEPTH - 1);
          end
          else if (drain_cnt == '0) state <= IDLE;
          else drain_cnt <= drain_cnt - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_relay_modulator.sv
// tb_relay_modulator: randomized scoreboard bench for relay_modulator against a behavioural model
module tb_relay_modulator;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  localparam int SAT = (1 << CNT_W) - 1;
  logic clk = 0, rst_n = 0, bit_tick = 0, data_in = 0;
  logic [2:0] mod_type = 3'b000;
  logic load_mod, carrier_off, busy;
  logic [CNT_W-1:0] tx_bits;
  relay_modulator #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bit_tick(bit_tick), .data_in(data_in), .mod_type(mod_type),
    .load_mod(load_mod), .carrier_off(carrier_off), .busy(busy), .tx_bits(tx_bits)
  );
  always #5 clk = ~clk;
  typedef struct {bit lm; bit co; bit bz; int tx;} exp_t;
  exp_t q[$];
  exp_t last;
  int n_cmp = 0, n_bad = 0;
  bit m_busy, m_tag;
  int m_left, m_cnt, m_sc;
  bit hist[$];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask
  task automatic model_reset();
    m_busy = 0; m_tag = 0; m_left = -1; m_cnt = 0; m_sc = 0;
    hist.delete();
    repeat (DEPTH) hist.push_back(1'b0);
  endtask
  // one clock: drive inputs, predict what the outputs show after the coming posedge
  task automatic drive(input bit t, input bit d, input logic [2:0] m);
    exp_t e;
    bit at, ar;
    @(negedge clk);
    rst_n = 1; bit_tick = t; data_in = d; mod_type = m;
    e.lm = m_busy && m_tag && hist[0] && m_sc >= 8;
    e.co = m_busy && !m_tag && !hist[0];
    e.bz = m_busy;
    m_sc = (m_sc + 1) % 16;
    if (t) begin
      at = m == 3'b010;
      ar = m == 3'b100;
      if (!m_busy) begin
        if (at || ar) begin
          m_busy = 1; m_tag = at; m_left = -1; m_cnt = 0;
        end
      end else begin
        m_cnt = (m_cnt == SAT) ? SAT : m_cnt + 1;
        if ((m_tag && at) || (!m_tag && ar)) m_left = -1;
        else if (m_left < 0) m_left = DEPTH - 1;
        else if (m_left == 0) m_busy = 0;
        else m_left--;
      end
      hist.push_back(d);
      void'(hist.pop_front());
    end
    e.tx = m_cnt;
    q.push_back(e);
    last = e;
  endtask
  task automatic ticks(input int n, input logic [2:0] m, input int d);
    repeat (n) begin
      drive(1'b1, d > 1 ? 1'($urandom_range(0, 1)) : 1'(d), m);
      repeat (15) drive(1'b0, 1'($urandom_range(0, 1)), m);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; bit_tick = 1;
    #1;
    chk("rst_load_mod", load_mod, 0);
    chk("rst_carrier_off", carrier_off, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_bits", tx_bits, 0);
    repeat (3) @(negedge clk);
    bit_tick = 0;
    model_reset();
  endtask
  task automatic random_run(input int n);
    int since;
    logic [2:0] cur;
    bit t;
    since = 0;
    cur = 3'b000;
    for (int i = 0; i < n; i++) begin
      t = (since >= 15) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 29) == 0);
      since = t ? 0 : since + 1;
      if (t && $urandom_range(0, 7) == 0)
        cur = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) :
              ($urandom_range(0, 1) ? 3'b010 : 3'b100);
      drive(t, 1'($urandom_range(0, 1)), cur);
    end
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("load_mod", load_mod, e.lm);
        chk("carrier_off", carrier_off, e.co);
        chk("busy", busy, e.bz);
        chk("tx_bits", tx_bits, e.tx);
        if (load_mod && carrier_off) chk("exclusive_drive", 1, 0);
      end
    end
  end
  initial begin : stim
    model_reset();
    #1;
    chk("init_load_mod", load_mod, 0);
    chk("init_carrier_off", carrier_off, 0);
    chk("init_busy", busy, 0);
    chk("init_tx_bits", tx_bits, 0);
    repeat (3) @(negedge clk);
    ticks(25, 3'b010, 2);
    ticks(6, 3'b100, 2);
    ticks(4, 3'b011, 2);
    ticks(3, 3'b100, 1);
    ticks(1, 3'b000, 0);
    ticks(2, 3'b100, 2);
    ticks(1, 3'b111, 2);
    ticks(3, 3'b100, 2);
    repeat (6) drive(1'b1, 1'($urandom_range(0, 1)), 3'b100);
    ticks(4, 3'b001, 2);
    random_run(2500);
    ticks(3, 3'b010, 1);
    for (int i = 0; i < 64 && !last.lm; i++) drive(1'b0, 1'b1, 3'b010);
    do_reset();
    ticks(3, 3'b000, 2);
    ticks(4, 3'b100, 2);
    random_run(2500);
    ticks(4, 3'b000, 2);
    repeat (3) @(negedge clk);
    if (q.size() != 0) chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
